// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared op/state encodings and constants for shift_sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int ID_W = 1;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate step
// SHIFT_SEQ_ROTATE_EN: when undefined, OP_ROL degrades to SLL and no rotate path exists.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = {value[WIDTH-2:0], 1'b0};
        case (op)
            OP_SRL: next = {1'b0, value[WIDTH-1:1]};
            OP_SRA: next = {value[WIDTH-1], value[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROL: next = {value[WIDTH-2:0], value[WIDTH-1]};
`else
            OP_ROL: next = {value[WIDTH-2:0], 1'b0};
`endif
            default: next = {value[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - two-requester round-robin serial shift engine
// SHIFT_SEQ_ROTATE_EN enables the ROL op (see shift_step).
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    state_t            state, state_nx;
    logic [WIDTH-1:0]  work, step_val, sel_data;
    logic [AMT_W-1:0]  cnt, sel_amt;
    logic [1:0]        sel_op;
    op_t               op_q;
    logic [ID_W-1:0]   id_q;
    logic              ptr;
    logic              grant0, grant1, accept;

    // ptr names the requester that wins when both are valid
    assign grant0   = req0_valid && (!req1_valid || !ptr);
    assign grant1   = req1_valid && (!req0_valid ||  ptr);
    assign accept   = (state == S_IDLE) && (grant0 || grant1);
    assign sel_data = grant1 ? req1_data : req0_data;
    assign sel_amt  = grant1 ? req1_amt  : req0_amt;
    assign sel_op   = grant1 ? req1_op   : req0_op;

    assign rsp_data = work;
    assign rsp_id   = id_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op    (op_q),
        .value (work),
        .next  (step_val)
    );

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy       = 1'b0;
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1)
                    state_nx = (sel_amt == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt == AMT_W'(1))
                    state_nx = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            work  <= '0;
            cnt   <= '0;
            op_q  <= OP_SLL;
            id_q  <= '0;
            ptr   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                work <= sel_data;
                cnt  <= sel_amt;
                op_q <= op_t'(sel_op);
                id_q <= grant1;
                ptr  <= !grant1;
            end else if (state == S_SHIFT) begin
                work <= step_val;
                cnt  <= cnt - 1'b1;
            end
        end
    end

endmodule
